imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. It replaces the single-mode clocked sign extender with four extension modes: zero, sign, upper-load and branch-offset. It uses a valid/ready handshake and a two-entry skid buffer, so decode can stall without losing an immediate. It sits between instruction decode and the ALU operand mux / branch-target adder.

## Interface
Parameters:
- IN_W, default 16: immediate field width. Must be ≥ 2.
- OUT_W, default 32: extended operand width. Must be ≥ IN_W + 2.

Ports:
- clock, input, 1: single clock. All state updates on posedge.
- reset, input, 1: synchronous, active-high. Clears all buffered state.
- in_valid, input, 1: in_data/in_mode are valid this cycle.
- in_ready, output, 1: unit accepts input this cycle.
- in_data, input, IN_W: raw immediate field.
- in_mode, input, 2: extension mode.
  - 00: zero-extend.
  - 01: sign-extend.
  - 10: upper (LUI).
  - 11: branch offset.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts out_data this cycle.
- out_data, output, OUT_W: extended result.
- out_mode, output, 2: mode that produced out_data. Travels with the data.

## Operation
Extension function, with d = in_data and E = OUT_W − IN_W:
- 00: {E zeros, d}.
- 01: {E copies of d[IN_W−1], d}.
- 10: {d, E zeros}. With the defaults this is d << 16.
- 11: {(E−2) copies of d[IN_W−1], d, 2'b00}. This is sign-extend, then shift left by 2.

Transfers:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.

Storage: two registered entries.
- Main output register: drives out_data, out_mode and out_valid.
- Skid register: skid_valid plus data and mode.

States (encoded by out_valid and skid_valid):
- EMPTY (0,0):
  - An input transfer loads the main register. Go to ONE.
- ONE (1,0):
  - Input transfer with output transfer: main register reloads. Stay in ONE.
  - Input transfer without output transfer: the result goes to skid. Go to FULL.
  - Output transfer only: go to EMPTY.
- FULL (1,1):
  - in_ready = 0.
  - On output transfer, skid moves into main and skid_valid clears. Go to ONE.

Handshake rules:
- in_ready = !skid_valid. It is a registered-state function only, with no combinational path from out_ready.
- out_data and out_mode are held stable while out_valid && !out_ready.
- The extension function is applied at capture time. Both stored entries hold already-extended values.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- in_data and in_mode are ignored when in_valid = 0.

Reset:
- reset = 1 at a clock edge forces out_valid = 0, skid_valid = 0 and out_data = 0, out_mode = 00, whatever the handshake state.
- Reset mid-stream discards both entries. in_ready reads 1 in the first cycle after reset.
- An input presented in the reset cycle is not captured.

## Timing
- Latency: 1 cycle. An input accepted at edge N appears on out_data after edge N, when the unit was EMPTY or drained that cycle.
- Throughput: 1 result per cycle while out_ready = 1.
- Stall response:
  - After out_ready drops, one more input is absorbed into skid.
  - in_ready goes low the cycle after skid fills.
  - When out_ready rises, in_ready returns high one cycle after the drain edge.
- Output values after reset: out_valid = 0, out_data = 0, out_mode = 00, in_ready = 1.
- No combinational path from any input to any output.

## Test plan
- Mode sweep, defaults, out_ready = 1:
  - in_data 0x8001 with modes 00/01/10/11 yields 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004.
  - in_data 0x7FFF, mode 11 yields 0x0001FFFC.
  - Each result appears one cycle after acceptance, with out_mode matching.
- Stall/skid:
  - Stream 0x0001..0x0005 in mode 01. Hold out_ready = 0 from the cycle after the first accept.
  - Exactly two values are buffered and in_ready goes 0.
  - On release, outputs 0x00000001..0x00000005 arrive in order with none lost.
- Backpressure hold:
  - out_valid = 1, out_ready = 0 for 5 cycles.
  - out_data and out_mode stay constant and in_valid toggling has no effect once FULL.
- Reset mid-operation:
  - In FULL state, assert reset for one cycle while in_valid = 1.
  - Next cycle: out_valid = 0, out_data = 0, in_ready = 1, and no output from the pre-reset data.
- Parameter variant, IN_W = 8, OUT_W = 16:
  - 0x80 in mode 01 gives 0xFF80.
  - 0x80 in mode 10 gives 0x8000.
  - 0xFF in mode 11 gives 0xFFFC.
  - Random valid/ready traffic is checked against a reference model for ordering and values.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: handshake bundle for imm_extend_pipe.
//   in_valid/in_ready/in_data/in_mode     : raw immediate stream from decode
//   out_valid/out_ready/out_data/out_mode : extended operand stream to the ALU mux
// Modports:
//   master : producer/consumer side (decode + operand mux, or a testbench)
//   slave  : the extension unit itself
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extender with a two-entry skid buffer.
// Modes: 00 zero-extend, 01 sign-extend, 10 upper (d << E), 11 branch offset
// (sign-extend then << 2). Extension happens at capture; both entries hold
// final operands. IN_W >= 2, OUT_W >= IN_W + 2.
// Ports:
//   clock : single clock, posedge
//   reset : synchronous active-high, clears both entries
//   bus   : imm_extend_pipe_if.slave (in_* stream in, out_* stream out)
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    imm_extend_pipe_if.slave   bus
);
    localparam int E = OUT_W - IN_W;

    // Encoding is {out_valid, skid_valid}, so the handshake flags fall
    // straight out of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] main_data_q, skid_data_q, ext_data;
    logic [1:0]       main_mode_q, skid_mode_q;
    logic             in_xfer, out_xfer;
    logic             load_main, load_skid, pop_skid;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                                input logic [1:0] mode);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] res;
        sext = {{E{d[IN_W-1]}}, d};
        case (mode)
            2'b00:   res = {{E{1'b0}}, d};
            2'b01:   res = sext;
            2'b10:   res = {d, {E{1'b0}}};
            default: res = sext << 2;   // drops the top two sign copies
        endcase
        return res;
    endfunction

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_data_q;
    assign bus.out_mode  = main_mode_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    always_comb begin
        ext_data = extend(bus.in_data, bus.in_mode);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_xfer) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    pop_skid = 1'b1;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_data_q <= '0;
            main_mode_q <= '0;
            skid_data_q <= '0;
            skid_mode_q <= '0;
        end else begin
            if (load_main) begin
                main_data_q <= ext_data;
                main_mode_q <= bus.in_mode;
            end else if (pop_skid) begin
                main_data_q <= skid_data_q;
                main_mode_q <= skid_mode_q;
            end
            if (load_skid) begin
                skid_data_q <= ext_data;
                skid_mode_q <= bus.in_mode;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: default (16->32) and narrow (8->16) instances.
module tb_imm_extend_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) dbus ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) sbus ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut_d (
        .clock (clk),
        .reset (rst),
        .bus   (dbus.slave)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut_s (
        .clock (clk),
        .reset (rst),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t dvec[5];
    vec_t svec[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic view of the extension rules: interpret the field as an
    // unsigned or two's-complement number, scale it, reduce mod 2^out_w.
    function automatic longint ref_ext(input int in_w, input int out_w,
                                       input longint d, input logic [1:0] m);
        longint s;
        longint r;
        s = (d >= (longint'(1) << (in_w - 1))) ? d - (longint'(1) << in_w) : d;
        case (m)
            2'b00:   r = d;
            2'b01:   r = s;
            2'b10:   r = d * (longint'(1) << (out_w - in_w));
            default: r = s * 4;
        endcase
        return r & ((longint'(1) << out_w) - 1);
    endfunction

    logic [15:0] got[$];
    logic [15:0] qd[$];
    logic [1:0]  qm[$];

    initial begin
        checks = 0;
        errors = 0;

        dvec[0] = '{16'h8001, 2'b00, 32'h0000_8001};
        dvec[1] = '{16'h8001, 2'b01, 32'hFFFF_8001};
        dvec[2] = '{16'h8001, 2'b10, 32'h8001_0000};
        dvec[3] = '{16'h8001, 2'b11, 32'hFFFE_0004};
        dvec[4] = '{16'h7FFF, 2'b11, 32'h0001_FFFC};
        svec[0] = '{16'h0080, 2'b01, 32'h0000_FF80};
        svec[1] = '{16'h0080, 2'b10, 32'h0000_8000};
        svec[2] = '{16'h00FF, 2'b11, 32'h0000_FFFC};

        rst = 1'b1;
        dbus.in_valid = 1'b0; dbus.in_data = '0; dbus.in_mode = '0; dbus.out_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_mode = '0; sbus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_d_valid", dbus.out_valid, 0);
        check("rst_d_data",  dbus.out_data, 0);
        check("rst_d_mode",  dbus.out_mode, 0);
        check("rst_d_ready", dbus.in_ready, 1);
        check("rst_s_valid", sbus.out_valid, 0);
        check("rst_s_ready", sbus.in_ready, 1);
        rst = 1'b0;
        tick();

        // Mode sweep, back to back, one-cycle latency
        for (int i = 0; i < 5; i++) begin
            dbus.in_valid = 1'b1;
            dbus.in_data  = dvec[i].din;
            dbus.in_mode  = dvec[i].mode;
            tick();
            check("sweep_d_valid", dbus.out_valid, 1);
            check("sweep_d_data",  dbus.out_data, dvec[i].exp);
            check("sweep_d_mode",  dbus.out_mode, dvec[i].mode);
            check("sweep_d_ready", dbus.in_ready, 1);
        end
        dbus.in_valid = 1'b0;
        tick();
        check("sweep_d_drain", dbus.out_valid, 0);

        for (int i = 0; i < 3; i++) begin
            sbus.in_valid = 1'b1;
            sbus.in_data  = dvec[0].din[7:0] & 8'h00 | svec[i].din[7:0];
            sbus.in_mode  = svec[i].mode;
            tick();
            check("sweep_s_valid", sbus.out_valid, 1);
            check("sweep_s_data",  sbus.out_data, svec[i].exp);
            check("sweep_s_mode",  sbus.out_mode, svec[i].mode);
        end
        sbus.in_valid = 1'b0;
        tick();
        check("sweep_s_drain", sbus.out_valid, 0);

        // Stall / skid with backpressure hold
        dbus.in_valid = 1'b1;
        dbus.in_mode  = 2'b01;
        dbus.in_data  = 16'h0001;
        tick();
        check("stall_first", dbus.out_data, 32'h1);
        dbus.out_ready = 1'b0;
        dbus.in_data   = 16'h0002;
        tick();
        check("stall_full_ready", dbus.in_ready, 0);
        check("stall_full_data",  dbus.out_data, 32'h1);
        for (int k = 0; k < 5; k++) begin
            dbus.in_valid = k[0];
            dbus.in_data  = 16'h00AA + 16'(k);
            dbus.in_mode  = 2'(k);
            tick();
            check("hold_valid", dbus.out_valid, 1);
            check("hold_data",  dbus.out_data, 32'h1);
            check("hold_mode",  dbus.out_mode, 2'b01);
            check("hold_ready", dbus.in_ready, 0);
        end
        begin
            int nxt;
            logic ox, ix;
            logic [31:0] od;
            nxt = 3;
            got.delete();
            dbus.in_valid  = 1'b1;
            dbus.in_data   = 16'(nxt);
            dbus.in_mode   = 2'b01;
            dbus.out_ready = 1'b1;
            for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
                ox = dbus.out_valid && dbus.out_ready;
                ix = dbus.in_valid && dbus.in_ready;
                od = dbus.out_data;
                tick();
                if (ox) got.push_back(od[15:0]);
                if (ix) nxt++;
                dbus.in_valid = (nxt <= 5);
                dbus.in_data  = 16'(nxt);
            end
            dbus.in_valid = 1'b0;
            check("drain_count", got.size(), 5);
            for (int i = 0; i < got.size(); i++) begin
                check("drain_order", got[i], i + 1);
            end
            check("drain_empty", dbus.out_valid, 0);
        end

        // Reset while FULL with an input offered
        dbus.out_ready = 1'b0;
        dbus.in_valid  = 1'b1;
        dbus.in_mode   = 2'b00;
        dbus.in_data   = 16'h0011;
        tick();
        dbus.in_data   = 16'h0022;
        tick();
        check("prerst_full", dbus.in_ready, 0);
        rst = 1'b1;
        dbus.in_data = 16'h0033;
        tick();
        rst = 1'b0;
        dbus.in_valid = 1'b0;
        check("mrst_valid", dbus.out_valid, 0);
        check("mrst_data",  dbus.out_data, 0);
        check("mrst_mode",  dbus.out_mode, 0);
        check("mrst_ready", dbus.in_ready, 1);
        dbus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mrst_noout", dbus.out_valid, 0);
        end

        // Random traffic on the narrow instance against a depth-2 FIFO model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qd.delete();
        qm.delete();
        for (int c = 0; c < 400; c++) begin
            logic push, pop;
            sbus.in_valid  = ($urandom % 4) != 0;
            sbus.in_data   = 8'($urandom);
            sbus.in_mode   = 2'($urandom);
            sbus.out_ready = ($urandom % 3) != 0;
            check("rnd_ready", sbus.in_ready, qd.size() < 2);
            check("rnd_valid", sbus.out_valid, qd.size() > 0);
            if (qd.size() > 0) begin
                check("rnd_data", sbus.out_data, qd[0]);
                check("rnd_mode", sbus.out_mode, qm[0]);
            end
            pop  = (qd.size() > 0) && sbus.out_ready;
            push = sbus.in_valid && (qd.size() < 2);
            if (pop) begin
                void'(qd.pop_front());
                void'(qm.pop_front());
            end
            if (push) begin
                qd.push_back(16'(ref_ext(8, 16, longint'(sbus.in_data), sbus.in_mode)));
                qm.push_back(sbus.in_mode);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
